// File: rtl/sng_fsm_mux_param.sv
// Stochastic number generator: N W-bit operands become N unipolar bitstreams of
// length 2^W via FSM/MUX low-discrepancy bit selection, with handshake and repeat.
module sng_fsm_mux_param #(
  parameter int unsigned W = 4,
  parameter int unsigned N = 4
) (
  input  logic         i_clk_sng,
  input  logic         i_rst_n_sng,
  input  logic         i_start_sng,
  input  logic         i_stop_sng,
  input  logic         i_repeat_sng,
  input  logic [W-1:0] i_x_bn [N-1:0],
  output logic         o_ready_sng,
  output logic         o_isgen,
  output logic [N-1:0] o_sn_bit,
  output logic         o_last_sng,
  output logic         o_done_sng
);

  localparam int unsigned SW = $clog2(W);

  typedef enum logic {IDLE, GEN} state_t;

  state_t         state, state_n;
  logic [W-1:0]   k, k_n;
  logic [W-1:0]   x_q [N-1:0];
  logic           done_q, done_n;
  logic           load;
  logic           last;
  logic           acc;
  logic [W-1:0]   kp1;
  logic [SW-1:0]  sel;
  logic           found;

  assign last        = (state == GEN) && (k == '1);
  assign o_isgen     = (state == GEN);
  assign o_ready_sng = (state == IDLE) || last;
  assign o_last_sng  = last;
  assign o_done_sng  = done_q;
  assign acc         = i_start_sng && o_ready_sng && !i_stop_sng;
  assign kp1         = k + W'(1);

  always_ff @(posedge i_clk_sng or negedge i_rst_n_sng) begin
    if (!i_rst_n_sng) begin
      state  <= IDLE;
      k      <= '0;
      done_q <= 1'b0;
      for (int unsigned c = 0; c < N; c++) x_q[c] <= '0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      done_q <= done_n;
      if (load) begin
        for (int unsigned c = 0; c < N; c++) x_q[c] <= i_x_bn[c];
      end
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    load    = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          state_n = GEN;
          k_n     = '0;
          load    = 1'b1;
        end
      end
      GEN: begin
        if (i_stop_sng) begin
          state_n = IDLE;
          k_n     = '0;
        end else if (!last) begin
          k_n = kp1;
        end else if (acc) begin
          k_n  = '0;
          load = 1'b1;
        end else if (i_repeat_sng) begin
          k_n = '0;
        end else begin
          state_n = IDLE;
          k_n     = '0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // sel = W-1-ctz(k+1): the lowest set bit of k+1 picks the operand bit
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && kp1[i]) begin
        sel   = SW'(W - 1 - i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    o_sn_bit = '0;
    if ((state == GEN) && !last) begin
      for (int unsigned c = 0; c < N; c++) o_sn_bit[c] = x_q[c][sel];
    end
  end

endmodule

// File: tb/tb_sng_fsm_mux_param.sv
// Scoreboard bench for sng_fsm_mux_param: stimulus pushes expected slots, a
// negedge monitor pops and compares; a second W=6,N=2 instance covers the sweep.
module tb_sng_fsm_mux_param;

  typedef logic [3:0] opv_t [3:0];
  typedef struct {
    logic [3:0] bits;
    bit         last;
    bit         fin;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, rep;
  opv_t       x_bn;
  logic       ready, isgen, last, done;
  logic [3:0] sn_bit;

  logic       start2;
  logic [5:0] x2 [1:0];
  logic       ready2, isgen2, last2, done2;
  logic [1:0] sn_bit2;
  logic       zero = 1'b0;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   valid_cnt, done_cnt;
  int   ones [4];
  bit   done_exp = 1'b0;

  always #5 clk = ~clk;

  sng_fsm_mux_param #(.W(4), .N(4)) dut (
    .i_clk_sng(clk), .i_rst_n_sng(rst_n), .i_start_sng(start), .i_stop_sng(stop),
    .i_repeat_sng(rep), .i_x_bn(x_bn), .o_ready_sng(ready), .o_isgen(isgen),
    .o_sn_bit(sn_bit), .o_last_sng(last), .o_done_sng(done)
  );

  sng_fsm_mux_param #(.W(6), .N(2)) dut2 (
    .i_clk_sng(clk), .i_rst_n_sng(rst_n), .i_start_sng(start2), .i_stop_sng(zero),
    .i_repeat_sng(zero), .i_x_bn(x2), .o_ready_sng(ready2), .o_isgen(isgen2),
    .o_sn_bit(sn_bit2), .o_last_sng(last2), .o_done_sng(done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bit j of x appears in the slots s where (s+1) mod 2^(w-j) equals 2^(w-1-j).
  function automatic bit ref_bit(input int x, input int s, input int w);
    if (s == (1 << w) - 1) return 1'b0;
    for (int j = 0; j < w; j++)
      if (((s + 1) % (1 << (w - j))) == (1 << (w - 1 - j))) return x[j];
    return 1'b0;
  endfunction

  task automatic push_stream(input opv_t v, input bit fin);
    exp_t e;
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < 4; c++) e.bits[c] = ref_bit(int'(v[c]), s, 4);
      e.last = (s == 15);
      e.fin  = fin && (s == 15);
      q.push_back(e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats;
    valid_cnt = 0;
    done_cnt  = 0;
    for (int c = 0; c < 4; c++) ones[c] = 0;
  endtask

  task automatic start_stream(input opv_t v, input bit fin);
    x_bn  = v;
    start = 1'b1;
    push_stream(v, fin);
    tick;
    start = 1'b0;
  endtask

  // Called in slot 0; returns in slot 15. Random start and operands mid-stream must be ignored.
  task automatic run_to_last;
    for (int s = 0; s < 15; s++) begin
      start = 1'($urandom);
      for (int c = 0; c < 4; c++) x_bn[c] = 4'($urandom);
      tick;
    end
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      done_exp = 1'b0;
    end else begin
      chk("done", 32'(done), 32'(done_exp));
      done_exp = 1'b0;
      if (done) done_cnt++;
      if (isgen) begin
        valid_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'(isgen), 0);
        end else begin
          e = q.pop_front();
          chk("sn_bit", 32'(sn_bit), 32'(e.bits));
          chk("last", 32'(last), 32'(e.last));
          for (int c = 0; c < 4; c++) ones[c] += int'(sn_bit[c]);
          done_exp = e.fin;
        end
      end else begin
        chk("idle_sn_bit", 32'(sn_bit), 0);
        chk("idle_last", 32'(last), 0);
      end
    end
  end

  initial begin
    opv_t v;
    int   p2 [2];
    int   v2cnt;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; rep = 1'b0; start2 = 1'b0;
    for (int c = 0; c < 4; c++) x_bn[c] = '0;
    x2[0] = '0; x2[1] = '0;
    clr_stats;

    // reset
    repeat (3) tick;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_isgen", 32'(isgen), 0);
    chk("rst_sn_bit", 32'(sn_bit), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_done", 32'(done), 0);

    // basic stream: x = {0,15,9,1}
    tick;
    clr_stats;
    v = '{4'd1, 4'd9, 4'd15, 4'd0};
    start_stream(v, 1'b1);
    run_to_last;
    tick;
    tick;
    chk("basic_valid", valid_cnt, 16);
    chk("basic_ones0", ones[0], 0);
    chk("basic_ones1", ones[1], 15);
    chk("basic_ones2", ones[2], 9);
    chk("basic_ones3", ones[3], 1);
    chk("basic_done", done_cnt, 1);

    // back-to-back: 9 then 6 on ch0
    clr_stats;
    for (int c = 0; c < 4; c++) v[c] = 4'($urandom);
    v[0] = 4'd9;
    start_stream(v, 1'b0);
    run_to_last;
    chk("b2b_ready_last", 32'(ready), 1);
    for (int c = 0; c < 4; c++) v[c] = 4'($urandom);
    v[0] = 4'd6;
    start_stream(v, 1'b1);
    run_to_last;
    tick;
    tick;
    chk("b2b_valid", valid_cnt, 32);
    chk("b2b_ones0", ones[0], 15);
    chk("b2b_done", done_cnt, 1);

    // repeat: three streams of the same operands
    clr_stats;
    for (int c = 0; c < 4; c++) v[c] = 4'($urandom);
    v[0] = 4'd5;
    start_stream(v, 1'b0);
    rep = 1'b1;
    run_to_last;
    push_stream(v, 1'b0);
    tick;
    run_to_last;
    push_stream(v, 1'b1);
    tick;
    run_to_last;
    rep = 1'b0;
    tick;
    tick;
    chk("rep_valid", valid_cnt, 48);
    chk("rep_ones0", ones[0], 15);
    chk("rep_done", done_cnt, 1);

    // abort at slot 5, then immediate restart
    clr_stats;
    for (int c = 0; c < 4; c++) v[c] = 4'($urandom);
    start_stream(v, 1'b1);
    repeat (5) tick;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    q.delete();
    chk("abort_isgen", 32'(isgen), 0);
    chk("abort_sn_bit", 32'(sn_bit), 0);
    chk("abort_ready", 32'(ready), 1);
    for (int c = 0; c < 4; c++) v[c] = 4'($urandom);
    start_stream(v, 1'b1);
    chk("abort_restart", 32'(isgen), 1);
    run_to_last;
    tick;
    tick;
    chk("abort_done", done_cnt, 1);

    // asynchronous reset at slot 8
    for (int c = 0; c < 4; c++) v[c] = 4'($urandom);
    start_stream(v, 1'b1);
    repeat (8) tick;
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mrst_isgen", 32'(isgen), 0);
    chk("mrst_sn_bit", 32'(sn_bit), 0);
    chk("mrst_ready", 32'(ready), 1);
    tick;
    rst_n = 1'b1;
    tick;
    clr_stats;
    for (int c = 0; c < 4; c++) v[c] = 4'($urandom);
    start_stream(v, 1'b1);
    run_to_last;
    tick;
    tick;
    chk("mrst_valid", valid_cnt, 16);
    chk("mrst_done", done_cnt, 1);
    chk("sb_empty", q.size(), 0);

    // parameter sweep: W=6, N=2, x = {37,63}
    x2[0] = 6'd37;
    x2[1] = 6'd63;
    p2[0] = 0; p2[1] = 0; v2cnt = 0;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    for (int s = 0; s < 64; s++) begin
      if (isgen2) v2cnt++;
      for (int c = 0; c < 2; c++) begin
        p2[c] += int'(sn_bit2[c]);
        chk("w6_bit", 32'(sn_bit2[c]), 32'(ref_bit(int'(x2[c]), s, 6)));
      end
      chk("w6_last", 32'(last2), (s == 63) ? 1 : 0);
      tick;
    end
    chk("w6_valid", v2cnt, 64);
    chk("w6_pop0", p2[0], 37);
    chk("w6_pop1", p2[1], 63);
    chk("w6_isgen_end", 32'(isgen2), 0);
    chk("w6_done", 32'(done2), 1);
    chk("w6_ready", 32'(ready2), 1);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sng_fsm_mux_param.md
# sng_fsm_mux_param

Parametrised stochastic number generator. Converts N unsigned W-bit binary operands into N parallel unipolar bitstreams of length L = 2^W. Each stream carries exactly x ones, representing x/L. Selection follows the deterministic FSM/MUX low-discrepancy pattern. It sits between the binary activation/weight buffers and the stochastic MAC array in `nn_wraper`. It supersedes the fixed 4×4-bit generator by adding:

- width and channel parameters,
- input latching,
- a ready/valid handshake,
- back-to-back and repeat modes,
- abort and completion signalling.

## Interface
Parameters:
- W, 4: operand width; stream length L = 2^W; W >= 2.
- N, 4: channel count; N >= 1.

Ports:
- i_clk_sng  in  1  clock; all state updates on rising edge.
- i_rst_n_sng  in  1  reset, asynchronous, active-low.
- i_start_sng  in  1  start request; accepted when o_ready_sng=1 and i_stop_sng=0.
- i_stop_sng  in  1  abort current stream; has priority over start and repeat.
- i_repeat_sng  in  1  at the last slot, restart with the same latched operands.
- i_x_bn  in  N×W  operands, unpacked array [N-1:0] of [W-1:0]; sampled only when start is accepted.
- o_ready_sng  out  1  start can be accepted this cycle.
- o_isgen  out  1  stream bits valid this cycle.
- o_sn_bit  out  N  stochastic bit per channel; 0 whenever o_isgen=0.
- o_last_sng  out  1  current slot is L-1.
- o_done_sng  out  1  one-cycle pulse after a stream completes and the block returns to IDLE.

## Operation
- States: IDLE, GEN.
- Registers:
  - slot counter k, W bits;
  - operand latch x_q[N];
  - state;
  - done flag.
- Start acceptance (acc) = i_start_sng & o_ready_sng & ~i_stop_sng. On acc, x_q <= i_x_bn and k <= 0.
- IDLE:
  - acc -> GEN.
  - Otherwise stay in IDLE.
- GEN with k < L-1:
  - i_stop_sng -> IDLE. k <= 0. No o_done_sng.
  - Otherwise k <= k+1.
  - i_start_sng is ignored.
- GEN with k = L-1, in priority order:
  - stop -> IDLE, no done.
  - acc -> GEN with new operands latched, k <= 0 (back-to-back).
  - i_repeat_sng -> GEN, k <= 0, x_q kept.
  - Otherwise -> IDLE, with o_done_sng asserted the following cycle.
- Bit selection for slot k < L-1:
  - sel = W-1-ctz(k+1), where ctz is the count of trailing zeros.
  - o_sn_bit[c] = x_q[c][sel].
  - Bit j of the operand is therefore selected 2^j times, interleaved.
- Slot L-1 always outputs 0 on every channel. The popcount over L slots is exactly x_q[c].
- Worked example for W=4: sel sequence is 3,2,3,1,3,2,3,0,3,2,3,1,3,2,3, then slot 15 outputs 0.
- Derived outputs:
  - o_isgen = (state==GEN).
  - o_ready_sng = (state==IDLE) | (state==GEN & k==L-1).
  - o_last_sng = (state==GEN & k==L-1).
- All outputs are decoded from registered state only. There is no combinational path from i_x_bn to o_sn_bit.
- Reset, at any time including mid-stream:
  - state IDLE, k=0, x_q=0, done flag=0, immediately.
  - Resulting outputs: o_isgen=0, o_sn_bit=0, o_last_sng=0, o_done_sng=0, o_ready_sng=1.

## Timing
- Start latency: acc at edge t gives slot 0 valid in cycle t+1. A stream occupies exactly L consecutive cycles.
- Back-to-back: the slot 0 of the new stream immediately follows slot L-1, with no bubble. o_done_sng is not pulsed between streams.
- Repeat: same as back-to-back, with no bubble and no done pulse.
- Abort: i_stop_sng high at edge t. o_isgen=0 and o_sn_bit=0 from cycle t+1. o_ready_sng=1 in t+1. A new start is accepted at edge t+1.
- o_done_sng: high for exactly the one cycle after the final slot L-1 of a non-continued stream. A start can be accepted in that same cycle.
- i_x_bn may change freely while o_ready_sng=0.

## Test plan
- Reset, W=4, N=4. Hold reset, then release. Required: o_ready_sng=1 and all other outputs 0.
- Basic stream, W=4, N=4, x={0,15,9,1}, start once. Required:
  - o_isgen high for 16 cycles.
  - Ones counts per channel are 0, 15, 9, 1.
  - ch1 is high in slots 0-14.
  - ch2 is high in slots {0,2,4,6,7,8,10,12,14}.
  - ch3 is high only in slot 7.
  - o_last_sng is high in slot 15.
  - o_done_sng pulses one cycle later.
- Back-to-back: x={9,…}, then at slot 15 start with x={6,…}. Required:
  - 32 contiguous valid cycles.
  - ch0 has 9 ones then 6 ones (6 falls in slots {1,3,5,9,11,13}).
  - A single o_done_sng at the end.
- Repeat and abort:
  - Repeat: x={5,…}, i_repeat_sng held high through 3 streams, then low. Required: 48 valid cycles, 15 ones on ch0, one done pulse.
  - Abort: separate run, stop at slot 5. Required: output 0 from the next cycle, no done pulse, and an immediate restart accepted.
- Reset mid-stream: assert reset asynchronously at slot 8 (between clock edges). Required: o_isgen and o_sn_bit drop to 0 without a clock edge. After release, a fresh start yields a correct full stream.
- Parameter sweep: W=6, N=2, x={37,63}. Required: 64 valid cycles, popcounts 37 and 63, o_last_sng at slot 63, slot 63 outputs 0.
